// File: rtl/j68_div_pkg.sv
// Shared types and constants for the J68 DIVU/DIVS sequencer.
// Signed support is controlled by J68_DIVS_EN in the sequencer itself.
package j68_div_pkg;

   localparam int unsigned DIV_STEPS = 16;
   localparam int unsigned STEP_W    = $clog2(DIV_STEPS);

   typedef enum logic [2:0] {
      StIdle,
      StAbs,
      StCheck,
      StIter,
      StSgnq,
      StSgnr,
      StDone
   } div_state_e;

   function automatic logic [15:0] neg16(input logic [15:0] v);
      return 16'(~v + 16'd1);
   endfunction

endpackage

// File: rtl/j68_div_seq_if.sv
// Request/result bundle between J68 microcode and the divide sequencer.
interface j68_div_seq_if;

   logic        start;
   logic        signed_op;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        ovf;
   logic        dbz;

   modport master (
      output start, signed_op, dividend, divisor,
      input  busy, done, quotient, remainder, ovf, dbz
   );

   modport slave (
      input  start, signed_op, dividend, divisor,
      output busy, done, quotient, remainder, ovf, dbz
   );

endinterface

// File: rtl/j68_addsub_32.sv
// 32-bit adder/subtractor; add_sub_i=0 subtracts and cout_o=1 then means no borrow.
module j68_addsub_32 (
   input  logic        add_sub_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] res_o,
   output logic        cout_o
);

   logic [32:0] sum;

   always_comb begin
      sum = {1'b0, a_i} + {1'b0, (add_sub_i ? b_i : ~b_i)} + {32'd0, ~add_sub_i};
   end

   assign res_o  = sum[31:0];
   assign cout_o = sum[32];

endmodule

// File: rtl/j68_div_seq.sv
// DIVU/DIVS sequencer: one restoring-division step per clock through a shared adder.
// Define J68_DIVS_EN to build the signed path (ABS/SGNQ/SGNR states).
module j68_div_seq
   import j68_div_pkg::*;
(
   input logic          clk,
   input logic          rst_n,
   j68_div_seq_if.slave bus
);

   div_state_e        state_q, state_d;
   logic [STEP_W-1:0] cnt_q, cnt_d;
   logic [31:0]       r_q, r_d;
   logic [31:0]       n_q, n_d;
   logic [15:0]       dmag_q, dmag_d;
   logic [15:0]       quo_q, quo_d;
   logic [15:0]       rem_q, rem_d;
   logic              ovf_q, ovf_d;
   logic              dbz_q, dbz_d;
   logic              sgn_path;

   logic [31:0]       add_a, add_b, add_res;
   logic              add_cout;

`ifdef J68_DIVS_EN
   logic sgn_q, sgn_d;
   logic dsgn_q, dsgn_d;
   logic qovf_q, qovf_d;
   logic qneg;

   assign sgn_path = sgn_q;
   assign qneg     = n_q[31] ^ dsgn_q;
`else
   logic unused_signed_op;

   assign sgn_path         = 1'b0;
   assign unused_signed_op = bus.signed_op;
`endif

   j68_addsub_32 u_addsub (
      .add_sub_i (1'b0),
      .a_i       (add_a),
      .b_i       (add_b),
      .res_o     (add_res),
      .cout_o    (add_cout)
   );

   // Every adder use is a subtraction; only the operands change per state.
   always_comb begin
      add_a = r_q;
      add_b = {dmag_q, 16'h0000};
      case (state_q)
         StIter: add_a = {r_q[30:0], 1'b0};
`ifdef J68_DIVS_EN
         StAbs: begin
            add_a = '0;
            add_b = n_q;
         end
         StSgnq: begin
            add_a = '0;
            add_b = {16'h0000, r_q[15:0]};
         end
         StSgnr: begin
            add_a = '0;
            add_b = {16'h0000, r_q[31:16]};
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      n_d     = n_q;
      dmag_d  = dmag_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      ovf_d   = ovf_q;
      dbz_d   = dbz_q;
`ifdef J68_DIVS_EN
      sgn_d   = sgn_q;
      dsgn_d  = dsgn_q;
      qovf_d  = qovf_q;
`endif
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               n_d     = bus.dividend;
               r_d     = bus.dividend;
               dmag_d  = bus.divisor;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               dbz_d   = 1'b0;
               state_d = StCheck;
`ifdef J68_DIVS_EN
               sgn_d   = bus.signed_op;
               dsgn_d  = bus.divisor[15];
               qovf_d  = 1'b0;
               if (bus.signed_op) begin
                  if (bus.divisor[15]) dmag_d = neg16(bus.divisor);
                  state_d = StAbs;
               end
`endif
            end
         end
`ifdef J68_DIVS_EN
         StAbs: begin
            if (n_q[31]) r_d = add_res;
            state_d = StCheck;
         end
`endif
         StCheck: begin
            if (dmag_q == 16'h0000) begin
               dbz_d   = 1'b1;
               state_d = StDone;
            end else if (add_cout) begin
               ovf_d   = 1'b1;
               quo_d   = n_q[15:0];
               rem_d   = n_q[31:16];
               state_d = StDone;
            end else begin
               state_d = StIter;
            end
         end
         StIter: begin
            // R[31] set means the shifted value exceeds 32 bits, so it always fits the divisor.
            if (r_q[31] | add_cout) r_d = add_res | 32'h0000_0001;
            else                    r_d = {r_q[30:0], 1'b0};
            cnt_d = cnt_q + STEP_W'(1);
            if (cnt_q == STEP_W'(DIV_STEPS - 1)) begin
               if (sgn_path) begin
                  state_d = StSgnq;
               end else begin
                  quo_d   = r_d[15:0];
                  rem_d   = r_d[31:16];
                  state_d = StDone;
               end
            end
         end
`ifdef J68_DIVS_EN
         StSgnq: begin
            if (qneg ? (r_q[15:0] > 16'h8000) : (r_q[15:0] > 16'h7FFF)) qovf_d = 1'b1;
            if (qneg) r_d[15:0] = add_res[15:0];
            state_d = StSgnr;
         end
         StSgnr: begin
            if (n_q[31]) r_d[31:16] = add_res[15:0];
            if (qovf_q) begin
               ovf_d = 1'b1;
               quo_d = n_q[15:0];
               rem_d = n_q[31:16];
            end else begin
               quo_d = r_d[15:0];
               rem_d = r_d[31:16];
            end
            state_d = StDone;
         end
`endif
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         r_q     <= '0;
         n_q     <= '0;
         dmag_q  <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
         dbz_q   <= 1'b0;
`ifdef J68_DIVS_EN
         sgn_q   <= 1'b0;
         dsgn_q  <= 1'b0;
         qovf_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         n_q     <= n_d;
         dmag_q  <= dmag_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         ovf_q   <= ovf_d;
         dbz_q   <= dbz_d;
`ifdef J68_DIVS_EN
         sgn_q   <= sgn_d;
         dsgn_q  <= dsgn_d;
         qovf_q  <= qovf_d;
`endif
      end
   end

   assign bus.busy      = (state_q != StIdle);
   assign bus.done      = (state_q == StDone);
   assign bus.quotient  = quo_q;
   assign bus.remainder = rem_q;
   assign bus.ovf       = ovf_q;
   assign bus.dbz       = dbz_q;

endmodule

// File: doc/j68_div_seq.md
# j68_div_seq

Multi-cycle sequencer for the 68000 DIVU/DIVS operation (32-bit dividend / 16-bit divisor -> 16-bit quotient + 16-bit remainder). It owns one j68_addsub_32 instance and drives it with one restoring-division step per clock. In signed mode it also uses that adder for the sign fix-ups. It sits beside the J68 ALU as a coprocessor: microcode issues `start`, then waits for `done`.

## Interface
- DIV_STEPS, 16: quotient bits produced, one per ITER cycle.
- clk  in  1  core clock; all flops rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- signed_op  in  1  1 = DIVS, 0 = DIVU; sampled with start.
- dividend  in  32  sampled with start.
- divisor  in  16  sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- quotient  out  16  result low word.
- remainder  out  16  result high word.
- ovf  out  1  quotient overflow; operand returned unchanged.
- dbz  out  1  divide by zero.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- States:
  - IDLE -> ABS on start when signed; IDLE -> CHECK on start when unsigned.
  - ABS -> CHECK -> ITER x16 -> SGNQ -> SGNR -> DONE when signed.
  - CHECK -> ITER x16 -> DONE when unsigned.
  - DONE -> IDLE.
- Register R[31:0] holds the partial remainder and quotient.
- Sampled operands D (divisor) and N (dividend) are kept for sign fix-up and unchanged-operand return.
- ABS: R = |N| via adder (0 - N when N[31]=1). |D| uses a local 16-bit two's-complement negate, not the adder. 0x80000000 and 0x8000 become unsigned magnitudes.
- CHECK:
  - D==0 -> dbz=1, go to DONE.
  - Otherwise adder computes R - {D,16'h0}. If cout=1 (R[31:16] >= D): ovf=1, go to DONE.
- ITER, step counter 0..15:
  - T = {R[30:0],1'b0}; adder computes T - {D,16'h0}.
  - If R[31] | cout: R = diff | 1. Else R = T.
- After ITER: quotient magnitude = R[15:0]; remainder magnitude = R[31:16].
- SGNQ:
  - Quotient negative when N[31]^D[15]; negated via adder.
  - ovf=1 when magnitude > 0x7FFF (positive result) or > 0x8000 (negative result).
- SGNR: remainder takes the sign of N; negated via adder when N[31]=1.
- On ovf (either path): quotient = N[15:0], remainder = N[31:16].
- On dbz: quotient and remainder hold their previous values.
- The adder is used only by this block; add_sub=0 in every state.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, ovf=0, dbz=0; state=IDLE.
- Start sampled at edge k.
  - busy=1 from cycle k+1 through the DONE cycle inclusive.
  - done=1 only in the DONE cycle.
- Latency from start edge to the done cycle:
  - unsigned: k+18.
  - signed: k+21.
  - dbz or CHECK-ovf: k+2 unsigned, k+3 signed.
  - SGNQ ovf does not shorten the sequence.
- Result ports, ovf and dbz update at DONE entry and hold until the next accepted start. ovf/dbz clear on accept.
- start while busy=1 is ignored (no queueing). Back-to-back: start may be asserted the cycle after done.
- rst_n low mid-operation: immediate return to reset values; no done pulse.

## Configuration
- J68_DIVS_EN defined: signed path, ABS/SGNQ/SGNR states and the 16-bit negate are present.
- J68_DIVS_EN undefined: signed_op is ignored and treated as 0. Those states and that logic are removed; unsigned timing is unchanged.

## Structure
- Package j68_div_pkg:
  - state enum (IDLE, ABS, CHECK, ITER, SGNQ, SGNR, DONE)
  - DIV_STEPS
  - step-counter width
- Sub-module: one j68_addsub_32 instance. No other sub-modules.

## Test plan
- DIVU 0x00010000 / 0x0003 -> quotient 0x5555, remainder 0x0001, ovf=0, done at k+18.
- DIVU 0x00030000 / 0x0003 -> ovf=1, quotient 0x0000, remainder 0x0003, done at k+2.
- DIVU 0x12345678 / 0x0000 -> dbz=1, ovf=0, done at k+2, previous results held.
- DIVS 0xFFFFFFF9 / 0x0002 -> quotient 0xFFFD, remainder 0xFFFF, done at k+21.
- DIVS boundaries:
  - 0x00008000 / 0x0001 -> ovf=1, outputs 0x8000 / 0x0000.
  - 0xFFFF8000 / 0x0001 -> quotient 0x8000, remainder 0x0000, ovf=0.
- Robustness:
  - start pulsed at k+5 of a DIVU is ignored; the first result is unaffected.
  - rst_n low during ITER -> all outputs 0 and no done pulse.
  - a new DIVU issued after reset completes correctly.
